// File: rtl/word_and_pkg.sv
// rtl/word_and_pkg.sv - shared FSM encoding and index-width helper for word_and_seq
package word_and_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ceil(log2(n)), but never less than one bit so a single-byte word still has an index port
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/word_and_seq_byte_and.sv
// rtl/word_and_seq_byte_and.sv - 8-bit AND-reduction unit shared across all bytes of a word
module word_and_seq_byte_and (
    input  logic [7:0] byte_data,
    output logic       byte_y
);

    // single reducer; the sequencer time-multiplexes bytes through it
    assign byte_y = &byte_data;

endmodule

// File: rtl/word_and_seq.sv
// rtl/word_and_seq.sv - byte-serial AND-reduction sequencer with early exit on first non-0xFF byte
module word_and_seq
    import word_and_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int IDXW   = clog2_min1(NBYTES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_y,
    output logic [IDXW-1:0]     out_first_zero,
    output logic                busy
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    state_t              state;
    logic [IDXW-1:0]     idx;
    logic [8*NBYTES-1:0] data_q;
    logic [7:0]          sel_byte;
    logic                byte_y;

    // handshake and activity flags come straight from the state
    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    // pick byte[idx] of the captured word; out-of-range idx values never occur
    always_comb begin
        sel_byte = 8'hFF;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx == IDXW'(k)) begin
                sel_byte = data_q[8*k +: 8];
            end
        end
    end

    word_and_seq_byte_and u_byte_and (
        .byte_data (sel_byte),
        .byte_y    (byte_y)
    );

    // control FSM, index counter and registered result; flush overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            idx            <= '0;
            data_q         <= '0;
            out_valid      <= 1'b0;
            out_y          <= 1'b0;
            out_first_zero <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        idx    <= '0;
                        state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!byte_y) begin
                        out_y          <= 1'b0;
                        out_first_zero <= idx;
                        out_valid      <= 1'b1;
                        state          <= ST_DONE;
                    end else if (idx == LAST_IDX) begin
                        out_y          <= 1'b1;
                        out_first_zero <= '0;
                        out_valid      <= 1'b1;
                        state          <= ST_DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_and_seq.sv
// tb/tb_word_and_seq.sv - randomized self-checking bench for word_and_seq (NBYTES=4 and NBYTES=1)
module tb_word_and_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic        sel1;
    logic [31:0] in_data;

    logic       ir4, ov4, y4, busy4;
    logic [1:0] fz4;
    logic       ir1, ov1, y1, busy1;
    logic [0:0] fz1;

    logic       cur_ir, cur_ov, cur_y, cur_busy;
    logic [1:0] cur_fz;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic hold_pend4 = 1'b0;
    logic hold_pend1 = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    word_and_seq #(.NBYTES(4)) dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid & ~sel1),
        .in_ready       (ir4),
        .in_data        (in_data),
        .out_valid      (ov4),
        .out_ready      (out_ready),
        .out_y          (y4),
        .out_first_zero (fz4),
        .busy           (busy4)
    );

    word_and_seq #(.NBYTES(1)) dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid & sel1),
        .in_ready       (ir1),
        .in_data        (in_data[7:0]),
        .out_valid      (ov1),
        .out_ready      (out_ready),
        .out_y          (y1),
        .out_first_zero (fz1),
        .busy           (busy1)
    );

    assign cur_ir   = sel1 ? ir1   : ir4;
    assign cur_ov   = sel1 ? ov1   : ov4;
    assign cur_y    = sel1 ? y1    : y4;
    assign cur_busy = sel1 ? busy1 : busy4;
    assign cur_fz   = sel1 ? {1'b0, fz1} : fz4;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // a presented result may only be withdrawn by out_ready, flush or reset
    always @(posedge clk) begin
        if (rst_n && hold_pend4) check("hold4", {63'd0, ov4}, 64'd1);
        if (rst_n && hold_pend1) check("hold1", {63'd0, ov1}, 64'd1);
        hold_pend4 <= rst_n && ov4 && !out_ready && !flush;
        hold_pend1 <= rst_n && ov1 && !out_ready && !flush;
    end

    // expected result: scan bytes low to high, stop at the first byte that is not 0xFF
    task automatic ref_calc(input logic [31:0] w, input int nb,
                            output logic y, output int fz, output int lat);
        y   = 1'b1;
        fz  = 0;
        lat = nb;
        for (int k = 0; k < nb; k++) begin
            if (w[8*k +: 8] != 8'hFF) begin
                y   = 1'b0;
                fz  = k;
                lat = k + 1;
                break;
            end
        end
    endtask

    // entered and left on a negative edge; hold = cycles out_ready stays low in DONE
    task automatic run_word(input logic [31:0] w, input int hold, input logic keep_valid);
        int   nb;
        logic ey;
        int   efz, elat, hs, lat_seen;
        logic seen;
        nb = sel1 ? 1 : 4;
        ref_calc(w, nb, ey, efz, elat);
        check("ready_before", {63'd0, cur_ir}, 64'd1);
        in_valid  = 1'b1;
        in_data   = w;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        hs = cyc;
        if (!keep_valid) in_valid = 1'b0;
        in_data  = $urandom;
        seen     = 1'b0;
        lat_seen = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (cur_ov) begin
                seen     = 1'b1;
                lat_seen = cyc - hs;
            end else begin
                in_data = $urandom;
            end
        end
        if (!seen) begin
            check("out_valid_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        check("latency", 64'(lat_seen), 64'(elat));
        check("out_y", {63'd0, cur_y}, {63'd0, ey});
        check("out_first_zero", {62'd0, cur_fz}, 64'(efz));
        check("busy_done", {63'd0, cur_busy}, 64'd1);
        check("in_ready_done", {63'd0, cur_ir}, 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            in_data = $urandom;
            check("held_valid", {63'd0, cur_ov}, 64'd1);
            check("held_y", {63'd0, cur_y}, {63'd0, ey});
            check("held_fz", {62'd0, cur_fz}, 64'(efz));
            check("held_in_ready", {63'd0, cur_ir}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("valid_drop", {63'd0, cur_ov}, 64'd0);
        check("idle_ready", {63'd0, cur_ir}, 64'd1);
        check("idle_busy", {63'd0, cur_busy}, 64'd0);
        check("spacing", 64'(cyc - hs + 1), 64'(elat + 2 + hold));
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) != 0) w[$urandom_range(0, 31)] = 1'b0;
        if ($urandom_range(0, 3) == 0) w[$urandom_range(0, 31)] = 1'b0;
        return w;
    endfunction

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel1      = 1'b0;
        in_data   = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'd0, ir4}, 64'd1);
        check("rst_out_valid", {63'd0, ov4}, 64'd0);
        check("rst_out_y", {63'd0, y4}, 64'd0);
        check("rst_fz", {62'd0, fz4}, 64'd0);
        check("rst_busy", {63'd0, busy4}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_word(32'hFFFF_FFFF, 0, 1'b0);
        run_word(32'hFFFE_FFFF, 0, 1'b0);
        run_word(32'hFFFF_FF7F, 5, 1'b0);

        // flush in SCAN: no result at all
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_scan_idle", {63'd0, ir4}, 64'd1);
        check("flush_scan_busy", {63'd0, busy4}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("flush_no_valid", {63'd0, ov4}, 64'd0);
        end

        // flush together with in_valid in IDLE: nothing captured
        in_valid = 1'b1;
        flush    = 1'b1;
        in_data  = 32'h0;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle_busy", {63'd0, busy4}, 64'd0);
        repeat (5) @(negedge clk);
        check("flush_idle_valid", {63'd0, ov4}, 64'd0);

        // async reset in the middle of a scan
        run_word(32'hFFFF_FFFF, 0, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", {63'd0, ir4}, 64'd1);
        check("arst_valid", {63'd0, ov4}, 64'd0);
        check("arst_y", {63'd0, y4}, 64'd0);
        check("arst_fz", {62'd0, fz4}, 64'd0);
        check("arst_busy", {63'd0, busy4}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            run_word(rand_word(), $urandom_range(0, 2), 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            run_word(rand_word(), 0, 1'b1);
        end
        in_valid = 1'b0;
        @(negedge clk);

        sel1 = 1'b1;
        run_word(32'h0000_00FF, 0, 1'b0);
        run_word(32'hFFFF_FF00, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            run_word(rand_word(), 0, 1'b1);
        end
        in_valid = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
